ram8_arbiter: RTL and testbench
===============================

// Module: ram8_arbiter
// PURPOSE
//  Two-requester round-robin arbiter/sequencer in front of one 8-word x 16-bit RAM port.
//  - Memory-side interface: data in, address, load strobe, combinational read data.
//  - Serialises read/write commands from two masters (e.g. CPU fetch and a program loader).
//  - Returns registered read data with a one-cycle ack per transaction.
// PARAMETERS
//  DATA_W  16  word width of requester and memory data buses
//  ADDR_W  3   memory address width (8 locations)
//  CNT_W   8   width of per-requester grant counters (RAM8_ARB_STATS_EN only)
// PORTS
//  clk        in   1       single clock, all state updates on posedge
//  rst_n      in   1       synchronous, active-low reset
//  req0/req1  in   1       requester n wants a transaction; held until its ack
//  we0/we1    in   1       1 = write, 0 = read; stable while req high
//  addr0/1    in   ADDR_W  word address; stable while req high
//  wdata0/1   in   DATA_W  write data; stable while req high
//  ack0/ack1  out  1       one-cycle pulse: transaction n complete
//  rdata      out  DATA_W  read data, valid only in the ack cycle of a read
//  mem_in     out  DATA_W  to memory data input
//  mem_addr   out  ADDR_W  to memory address
//  mem_load   out  1       to memory write enable
//  mem_out    in   DATA_W  from memory combinational read data
// BEHAVIOUR
//  - Reset (rst_n low at posedge) gives: state=IDLE, ack0=ack1=0, rdata=0, mem_in=0, mem_addr=0, last_gnt=1.
//  - mem_load is decoded as (state==ACCESS && cmd_we); it is 0 in every other state.
//  - FSM states and transitions:
//      IDLE:   sample req0/req1; if none, stay. If any, latch the winner's we/addr/wdata into
//              cmd_*, set owner, -> ACCESS.
//      ACCESS: mem_addr/mem_in driven from cmd_*; a write commits at this cycle's edge;
//              on a read, mem_out is captured into rdata at this edge; -> DONE.
//      DONE:   ack[owner]=1 for this cycle only; last_gnt<=owner; -> IDLE.
//  - Latency: req sampled in IDLE cycle N -> ack in cycle N+2. Max throughput is 1 transaction per 3 cycles.
//  - Arbitration: if both requests are high, grant the requester != last_gnt. A single request wins outright.
//    After reset, requester 0 wins the first contention.
//  - Handshake: requester holds req and its fields until ack. If req stays high in the cycle
//    after ack, that is a new transaction.
//  - Dropping req before ack is a protocol violation. The latched command still completes and acks.
//  - A request from the non-owner during ACCESS/DONE is held off and is not lost; it is
//    sampled at the next IDLE.
//  - rdata holds its last value outside read acks. A write ack leaves rdata unchanged.
//  - Address wrap: none. ADDR_W bits map 1:1 to the 8 locations.
//  - Reset mid-operation: the transaction is aborted and no ack is issued. A write whose ACCESS
//    cycle coincides with the reset edge still commits, because the memory has no reset.
// CONFIGURATION
//  RAM8_ARB_STATS_EN defined:
//    - Adds outputs gnt_cnt0/gnt_cnt1 [CNT_W-1:0].
//    - Each counter increments on its requester's ack and saturates at all-ones.
//    - Both counters are cleared by rst_n.
//  RAM8_ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.
// STRUCTURE
//  - Package ram8_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the
//    DATA_W/ADDR_W defaults.
//  - Sub-module rr_arb2: combinational 2-way round-robin pick (req0, req1, last_gnt -> valid, winner).
//  - The top holds the FSM, the command latch, rdata and the optional counters.
// TESTING
//  - Reset then idle: rst_n=0 for 2 cycles, no reqs -> ack0=ack1=0, mem_load=0, rdata=0 indefinitely.
//  - Single write/read: req0 write addr=5 data=16'hBEEF -> ack0 at N+2, mem_load high only in ACCESS;
//    then req0 read addr=5 -> ack0 with rdata=16'hBEEF.
//  - Contention: req0 read addr=1 and req1 read addr=2 asserted together and held ->
//    ack0, then ack1 3 cycles later, then alternate 0,1,0,1.
//  - Non-owner hold-off: req1 write addr=7 data=16'h1234 raised during req0's ACCESS ->
//    ack1 exactly 3 cycles after ack0; read addr=7 returns 16'h1234.
//  - Reset mid-op: rst_n low during a read's ACCESS -> no ack; state IDLE; the next read still works.
//  - STATS (macro on): 300 acks on requester 0 -> gnt_cnt0=8'hFF and stays there; gnt_cnt1 unaffected.

Source files
------------

// File: rtl/ram8_arbiter_pkg.sv
// Shared widths and FSM state encoding for the two-requester RAM8 arbiter.
package ram8_arb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/ram8_arbiter_if.sv
// Requester and memory-side signals of ram8_arbiter; slave = arbiter, master = environment.
interface ram8_arbiter_if #(
  parameter int DATA_W = ram8_arb_pkg::DATA_W,
  parameter int ADDR_W = ram8_arb_pkg::ADDR_W
);
  logic              req0, req1;
  logic              we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] mem_in;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    output ack0, ack1, rdata, mem_in, mem_addr, mem_load
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_out,
    input  ack0, ack1, rdata, mem_in, mem_addr, mem_load
  );
endinterface

// File: rtl/ram8_arbiter_rr_arb2.sv
// Combinational 2-way round-robin pick: on contention the requester that was not
// granted last wins; a lone request wins outright.
module rr_arb2 (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_valid,
  output logic o_winner
);
  assign o_valid  = i_req0 | i_req1;
  assign o_winner = (i_req0 & i_req1) ? ~i_last_gnt : i_req1;
endmodule

// File: rtl/ram8_arbiter.sv
// Round-robin sequencer for two masters sharing one 8x16 RAM port (IDLE->ACCESS->DONE).
// Optional grant counters are built when RAM8_ARB_STATS_EN is defined.
module ram8_arbiter
  import ram8_arb_pkg::*;
#(
  parameter int DATA_W = ram8_arb_pkg::DATA_W,
  parameter int ADDR_W = ram8_arb_pkg::ADDR_W,
  parameter int CNT_W  = ram8_arb_pkg::CNT_W
) (
  input  logic           clk,
  input  logic           rst_n,
  ram8_arbiter_if.slave  bus
`ifdef RAM8_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);
  state_t            r_state, w_next;
  logic              r_owner, r_last_gnt, r_cmd_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_in, r_rdata;
  logic              w_valid, w_winner;
  logic              w_ack0, w_ack1, w_load;

  rr_arb2 u_arb (
    .i_req0    (bus.req0),
    .i_req1    (bus.req1),
    .i_last_gnt(r_last_gnt),
    .o_valid   (w_valid),
    .o_winner  (w_winner)
  );

  always_comb begin
    w_next = r_state;
    w_ack0 = 1'b0;
    w_ack1 = 1'b0;
    w_load = 1'b0;
    case (r_state)
      IDLE:   if (w_valid) w_next = ACCESS;
      ACCESS: begin
        w_load = r_cmd_we;
        w_next = DONE;
      end
      DONE: begin
        w_ack0 = ~r_owner;
        w_ack1 = r_owner;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // mem_addr/mem_in double as the command latch for address and write data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last_gnt <= 1'b1;
      r_cmd_we   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_in   <= '0;
      r_rdata    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: if (w_valid) begin
          r_owner    <= w_winner;
          r_cmd_we   <= w_winner ? bus.we1    : bus.we0;
          r_mem_addr <= w_winner ? bus.addr1  : bus.addr0;
          r_mem_in   <= w_winner ? bus.wdata1 : bus.wdata0;
        end
        ACCESS: if (!r_cmd_we) r_rdata <= bus.mem_out;
        DONE:   r_last_gnt <= r_owner;
        default: ;
      endcase
    end
  end

  assign bus.ack0     = w_ack0;
  assign bus.ack1     = w_ack1;
  assign bus.mem_load = w_load;
  assign bus.mem_addr = r_mem_addr;
  assign bus.mem_in   = r_mem_in;
  assign bus.rdata    = r_rdata;

`ifdef RAM8_ARB_STATS_EN
  logic [CNT_W-1:0] r_cnt0, r_cnt1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_ack0 && r_cnt0 != '1) r_cnt0 <= r_cnt0 + CNT_W'(1);
      if (w_ack1 && r_cnt1 != '1) r_cnt1 <= r_cnt1 + CNT_W'(1);
    end
  end

  assign gnt_cnt0 = r_cnt0;
  assign gnt_cnt1 = r_cnt1;
`endif
endmodule

// File: tb/tb_ram8_arbiter.sv
// Scoreboard bench for ram8_arbiter: drivers queue expected responses, a negedge
// monitor pops them on every ack. Reference memory is a plain array of words.
module tb_ram8_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ram8_arbiter_if bus ();

`ifdef RAM8_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
  ram8_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus), .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1));
`else
  ram8_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  // The RAM itself (environment, no reset)
  logic [15:0] mem [8];
  always @(posedge clk) if (bus.mem_load) mem[bus.mem_addr] <= bus.mem_in;
  assign bus.mem_out = mem[bus.mem_addr];

  typedef struct { bit rd; logic [15:0] d; } exp_t;
  exp_t        q0[$], q1[$];
  logic [15:0] ref_mem [8];
  logic [15:0] last_rd = 16'h0;
  int          cnt0_m = 0, cnt1_m = 0;
  int          ack_id[$], ack_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_ack(input int id);
    exp_t e;
    ack_id.push_back(id);
    ack_cyc.push_back(cyc);
    if (id == 0) cnt0_m = (cnt0_m < 255) ? cnt0_m + 1 : 255;
    else         cnt1_m = (cnt1_m < 255) ? cnt1_m + 1 : 255;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      checks++; errors++;
      $display("FAIL unexpected_ack%0d: got ack expected none (cycle %0d)", id, cyc);
    end else begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      if (e.rd) begin
        chk($sformatf("rdata%0d", id), bus.rdata, e.d);
        last_rd = e.d;
      end else begin
        chk($sformatf("rdata_hold%0d", id), bus.rdata, last_rd);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ack0 && bus.ack1) begin
        checks++; errors++;
        $display("FAIL dual_ack: got both acks expected one (cycle %0d)", cyc);
      end
      if (bus.ack0) mon_ack(0);
      if (bus.ack1) mon_ack(1);
    end
  end

  task automatic set_req(input int id, input bit v);
    if (id == 0) bus.req0 = v; else bus.req1 = v;
  endtask

  // Issue one transaction from requester id; caller is at posedge+1.
  task automatic txn(input int id, input bit we, input logic [2:0] a,
                     input logic [15:0] d, input bit solo);
    exp_t e;
    int n, ld;
    bit got;
    e.rd = !we;
    e.d  = we ? 16'h0 : ref_mem[a];
    if (we) ref_mem[a] = d;
    if (id == 0) begin
      q0.push_back(e); bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      q1.push_back(e); bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
    set_req(id, 1'b1);
    got = 1'b0; n = 0; ld = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mem_load) ld++;
      got = (id == 0) ? bus.ack0 : bus.ack1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout%0d: got no ack expected ack within 40 cycles", id);
    end
    if (solo) begin
      chk("latency", n, 3);
      chk("load_cycles", ld, {31'b0, we});
    end
    @(posedge clk); #1;
    set_req(id, 1'b0);
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    last_rd = 16'h0;
    cnt0_m  = 0;
    cnt1_m  = 0;
  endtask

  task automatic check_seq(input string name, input int n_exp);
    chk({name, "_count"}, ack_id.size(), n_exp);
    for (int i = 0; i < n_exp && i < ack_id.size(); i++) begin
      chk($sformatf("%s_order%0d", name, i), ack_id[i], i % 2);
      if (i > 0) chk($sformatf("%s_gap%0d", name, i), ack_cyc[i] - ack_cyc[i-1], 3);
    end
  endtask

  initial begin
    int k;
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;

    // Reset then idle
    apply_reset(2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_outputs", {bus.ack0, bus.ack1, bus.mem_load, bus.rdata, bus.mem_addr, bus.mem_in},
          '0);
    end
    @(posedge clk); #1;

    // Fill memory with known data from requester 0
    for (int a = 0; a < 8; a++) txn(0, 1'b1, 3'(a), 16'($urandom), 1'b1);

    // Contention right after reset: 0 wins first, then strict alternation
    apply_reset(2);
    ack_id.delete(); ack_cyc.delete();
    fork
      for (int i = 0; i < 3; i++) txn(0, 1'b0, 3'd1, 16'h0, 1'b0);
      for (int i = 0; i < 3; i++) txn(1, 1'b0, 3'd2, 16'h0, 1'b0);
    join
    check_seq("contention", 6);

    // Single write/read
    txn(0, 1'b1, 3'd5, 16'hBEEF, 1'b1);
    txn(0, 1'b0, 3'd5, 16'h0, 1'b1);

    // Non-owner hold-off: req1 raised during req0's ACCESS
    ack_id.delete(); ack_cyc.delete();
    fork
      txn(0, 1'b1, 3'd3, 16'h5A5A, 1'b0);
      begin @(posedge clk); #1; txn(1, 1'b1, 3'd7, 16'h1234, 1'b0); end
    join
    check_seq("holdoff", 2);
    txn(0, 1'b0, 3'd7, 16'h0, 1'b1);

    // Reset during a read's ACCESS: aborted, no ack
    bus.we0 = 1'b0; bus.addr0 = 3'd4; bus.req0 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.req0 = 1'b0; last_rd = 16'h0; cnt0_m = 0; cnt1_m = 0;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1 || bus.mem_load) k++;
    end
    chk("rst_read_noack", k, 0);
    chk("rst_rdata", bus.rdata, 16'h0);
    @(posedge clk); #1;
    txn(0, 1'b0, 3'd4, 16'h0, 1'b1);

    // Reset during a write's ACCESS: write still commits, no ack
    bus.we0 = 1'b1; bus.addr0 = 3'd6; bus.wdata0 = 16'hC0DE; bus.req0 = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; bus.req0 = 1'b0; last_rd = 16'h0; cnt0_m = 0; cnt1_m = 0;
    ref_mem[6] = 16'hC0DE;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) k++;
    end
    chk("rst_write_noack", k, 0);
    @(posedge clk); #1;
    txn(1, 1'b0, 3'd6, 16'h0, 1'b1);

    // Randomized traffic, disjoint address halves per requester
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        txn(0, 1'($urandom), 3'($urandom_range(0, 3)), 16'($urandom), 1'b0);
      end
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        txn(1, 1'($urandom), 3'($urandom_range(4, 7)), 16'($urandom), 1'b0);
      end
    join
    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

`ifdef RAM8_ARB_STATS_EN
    for (int i = 0; i < 300; i++) txn(0, 1'b1, 3'd0, 16'($urandom), 1'b0);
    @(negedge clk);
    chk("gnt_cnt0_sat", gnt_cnt0, 8'hFF);
    chk("gnt_cnt0_model", gnt_cnt0, 8'(cnt0_m));
    chk("gnt_cnt1_model", gnt_cnt1, 8'(cnt1_m));
    @(posedge clk); #1;
    txn(0, 1'b0, 3'd0, 16'h0, 1'b0);
    @(negedge clk);
    chk("gnt_cnt0_hold", gnt_cnt0, 8'hFF);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
